expr_str_tx: RTL and testbench

- Serial ASCII generator for arithmetic-expression strings of the form digit (op digit)*, e.g. "0+1*5".
- It is the transmit-side counterpart of the string recogniser: it feeds a well-formed character stream, one 8-bit char per accepted handshake, into the recogniser input or a test harness.
- Operands and operators are loaded in parallel, then emitted in order under valid/ready flow control.

---
 rtl/expr_str_tx_pkg.sv | 27 ++
 rtl/expr_char_enc.sv | 31 +++
 rtl/expr_str_tx.sv | 173 +++++++++++++++++
 tb/tb_expr_str_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_str_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : expr_str_tx_pkg
// Purpose  : Shared ASCII constants, operator encoding and FSM states for
//            the expression string transmitter.
// Revision : 1.0  initial release
// ============================================================================
package expr_str_tx_pkg;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIGIT = 3'd1,
    S_OP    = 3'd2,
    S_TERM  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

endpackage : expr_str_tx_pkg
`default_nettype wire

// File: rtl/expr_char_enc.sv
`default_nettype none
// ============================================================================
// Module   : expr_char_enc
// Purpose  : Combinational map of {is_op, op_bit, digit} to ASCII, flagging
//            operands outside 0..9 (those are emitted as '0').
// Revision : 1.0  initial release
// ============================================================================
module expr_char_enc (
  input  logic       is_op,
  input  logic       op_bit,
  input  logic [3:0] digit,
  output logic [7:0] ch,
  output logic       inv
);
  import expr_str_tx_pkg::*;

  always_comb begin
    inv = 1'b0;
    ch  = CH_ZERO;
    if (is_op) begin
      ch = (op_bit == OP_MUL) ? CH_MUL : CH_PLUS;
    end else if (digit > 4'd9) begin
      inv = 1'b1;
      ch  = CH_ZERO;
    end else begin
      ch = CH_ZERO + {4'b0000, digit};
    end
  end

endmodule : expr_char_enc
`default_nettype wire

// File: rtl/expr_str_tx.sv
`default_nettype none
// ============================================================================
// Module   : expr_str_tx
// Purpose  : Parallel-load, valid/ready serial generator of expression
//            strings "d(op d)*". Optional macro EXPR_TERM_EN appends '='.
// Revision : 1.0  initial release
// ============================================================================
module expr_str_tx #(
  parameter int MAX_OPS = 4,
  parameter int CW      = $clog2(MAX_OPS + 1)
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     start,
  input  logic [4*(MAX_OPS+1)-1:0] digits,
  input  logic [MAX_OPS-1:0]       ops,
  input  logic [CW-1:0]            n_ops,
  output logic [7:0]               ch,
  output logic                     ch_valid,
  input  logic                     ch_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  import expr_str_tx_pkg::*;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CW-1:0]              r_idx;
  logic [CW-1:0]              w_idx_nxt;
  logic [4*(MAX_OPS+1)-1:0]   r_digits;
  logic [MAX_OPS-1:0]         r_ops;
  logic [CW-1:0]              r_nops;
  logic                       r_errf;
  logic [7:0]                 r_ch;
  logic                       r_ch_valid;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;

  logic                       w_hs;
  logic                       w_load;
  logic [CW-1:0]              w_nops_eff;
  logic [4*(MAX_OPS+1)-1:0]   w_dig_src;
  logic [3:0]                 w_dig;
  logic                       w_opb;
  logic                       w_is_op;
  logic [7:0]                 w_enc_ch;
  logic                       w_enc_inv;

  assign w_hs       = r_ch_valid & ch_ready;
  assign w_nops_eff = (n_ops > CW'(MAX_OPS)) ? CW'(MAX_OPS) : n_ops;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_DIGIT;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      S_DIGIT: begin
        if (w_hs) begin
          if (r_idx == r_nops) begin
`ifdef EXPR_TERM_EN
            w_state_nxt = S_TERM;
`else
            w_state_nxt = S_FIN;
`endif
          end else begin
            w_state_nxt = S_OP;
          end
        end
      end
      S_OP: begin
        if (w_hs) begin
          w_state_nxt = S_DIGIT;
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
`ifdef EXPR_TERM_EN
      S_TERM: begin
        if (w_hs) begin
          w_state_nxt = S_FIN;
        end
      end
`endif
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The next character is encoded ahead of time so ch leaves a flop; on load
  // operand 0 comes straight from the input bus.
  always_comb begin
    w_dig_src = w_load ? digits : r_digits;
    w_dig     = 4'd0;
    w_opb     = 1'b0;
    for (int k = 0; k <= MAX_OPS; k++) begin
      if (w_idx_nxt == CW'(k)) w_dig = w_dig_src[4*k +: 4];
    end
    for (int k = 0; k < MAX_OPS; k++) begin
      if (w_idx_nxt == CW'(k)) w_opb = r_ops[k];
    end
  end

  assign w_is_op = (w_state_nxt == S_OP);

  expr_char_enc u_enc (
    .is_op  (w_is_op),
    .op_bit (w_opb),
    .digit  (w_dig),
    .ch     (w_enc_ch),
    .inv    (w_enc_inv)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_digits   <= '0;
      r_ops      <= '0;
      r_nops     <= '0;
      r_errf     <= 1'b0;
      r_ch       <= 8'h00;
      r_ch_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) begin
        r_digits <= digits;
        r_ops    <= ops;
        r_nops   <= w_nops_eff;
        r_errf   <= w_enc_inv;
      end else if (w_state_nxt == S_DIGIT) begin
        r_errf   <= r_errf | w_enc_inv;
      end
      case (w_state_nxt)
        S_DIGIT, S_OP: begin
          r_ch       <= w_enc_ch;
          r_ch_valid <= 1'b1;
        end
        S_TERM: begin
          r_ch       <= CH_EQ;
          r_ch_valid <= 1'b1;
        end
        default: begin
          r_ch       <= 8'h00;
          r_ch_valid <= 1'b0;
        end
      endcase
      r_busy <= (w_state_nxt == S_DIGIT) || (w_state_nxt == S_OP) ||
                (w_state_nxt == S_TERM);
      r_done <= (w_state_nxt == S_FIN);
      r_err  <= (w_state_nxt == S_FIN) & r_errf;
    end
  end

  assign ch       = r_ch;
  assign ch_valid = r_ch_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule : expr_str_tx
`default_nettype wire

// File: tb/tb_expr_str_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_str_tx
// Purpose  : Directed self-checking bench for expr_str_tx.
// Revision : 1.0  initial release
// ============================================================================
module tb_expr_str_tx;
  localparam int MAX_OPS = 4;
  localparam int CW      = $clog2(MAX_OPS + 1);
  localparam int DW      = 4 * (MAX_OPS + 1);

  logic          clk = 1'b0;
  logic          clr_n;
  logic          start;
  logic [DW-1:0] digits;
  logic [MAX_OPS-1:0] ops;
  logic [CW-1:0] n_ops;
  logic [7:0]    ch;
  logic          ch_valid;
  logic          ch_ready;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  expr_str_tx #(.MAX_OPS(MAX_OPS)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .digits   (digits),
    .ops      (ops),
    .n_ops    (n_ops),
    .ch       (ch),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap [0:31];
  int  ncap, stall_viol, first_v, last_hs, done_cyc, err_stray;
  bit  done_seen, err_at_done, busy_at_done;
  string term;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a load for one cycle, then scramble the inputs to prove they are latched.
  task automatic load(input logic [DW-1:0] d, input logic [MAX_OPS-1:0] o, input logic [CW-1:0] n);
    digits = d;
    ops    = o;
    n_ops  = n;
    start  = 1'b1;
    step();
    start  = 1'b0;
    digits = ~d;
    ops    = ~o;
    n_ops  = CW'(1);
  endtask

  // Sink model: captures accepted chars and records timing/stall observations.
  task automatic collect(input int mode, input int budget, input int start_at);
    bit         prev_stall;
    logic [7:0] prev_ch;
    bit         rdy;
    ncap = 0; stall_viol = 0; first_v = -1; last_hs = -1; done_cyc = -1;
    err_stray = 0; done_seen = 0; err_at_done = 0; busy_at_done = 1;
    prev_stall = 0; prev_ch = 8'h00;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done === 1'b1) begin
        done_seen    = 1;
        done_cyc     = cyc;
        err_at_done  = err;
        busy_at_done = busy;
        break;
      end
      if (err === 1'b1) err_stray++;
      if (prev_stall && (ch_valid !== 1'b1 || ch !== prev_ch)) stall_viol++;
      if (ch_valid === 1'b1 && first_v < 0) first_v = cyc;
      rdy      = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      ch_ready = rdy;
      start    = (cyc == start_at);
      if (ch_valid === 1'b1 && rdy) begin
        if (ncap < 32) cap[ncap] = ch;
        ncap++;
        last_hs = cyc;
      end
      prev_stall = (ch_valid === 1'b1) && !rdy;
      prev_ch    = ch;
      step();
    end
    start    = 1'b0;
    ch_ready = 1'b1;
  endtask

  function automatic string cap_str();
    string s = "";
    for (int i = 0; i < ncap && i < 32; i++) s = $sformatf("%s%c", s, cap[i]);
    return s;
  endfunction

  task automatic test_reset();
    clr_n = 1'b0; start = 1'b0; ch_ready = 1'b0;
    digits = '0; ops = '0; n_ops = '0;
    step(); step();
    n_checks++; if (ch !== 8'h00) begin n_fail++; $display("FAIL reset_ch: got %h want 00", ch); end
    n_checks++; if (ch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ch_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    clr_n = 1'b1;
    step();
    n_checks++; if (ch_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: valid=%b busy=%b want 0 0", ch_valid, busy); end
  endtask

  task automatic test_basic();
    string exp = {"0+1*5", term};
    string got;
    ch_ready = 1'b1;
    load(20'h00510, 4'b0010, 3'd2);
    collect(0, 40, -1);
    got = cap_str();
    n_checks++; if (got != exp) begin n_fail++; $display("FAIL basic_seq: got \"%s\" want \"%s\"", got, exp); end
    n_checks++; if (first_v != 0) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d want 0", first_v); end
    n_checks++; if (last_hs != exp.len() - 1) begin n_fail++; $display("FAIL basic_back_to_back: last handshake cycle %0d want %0d", last_hs, exp.len() - 1); end
    n_checks++; if (!done_seen || done_cyc != last_hs + 1) begin n_fail++; $display("FAIL basic_done: seen=%0d cycle %0d want %0d", done_seen, done_cyc, last_hs + 1); end
    n_checks++; if (err_at_done !== 1'b0 || err_stray != 0) begin n_fail++; $display("FAIL basic_err: err=%b stray=%0d want 0 0", err_at_done, err_stray); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fin: got %b want 0", busy_at_done); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_stall();
    string exp = {"0+1*5", term};
    string got;
    ch_ready = 1'b1;
    load(20'h00510, 4'b0010, 3'd2);
    collect(1, 80, -1);
    got = cap_str();
    n_checks++; if (got != exp) begin n_fail++; $display("FAIL stall_seq: got \"%s\" want \"%s\"", got, exp); end
    n_checks++; if (stall_viol != 0) begin n_fail++; $display("FAIL stall_hold: got %0d violations want 0", stall_viol); end
    n_checks++; if (!done_seen || done_cyc != last_hs + 1) begin n_fail++; $display("FAIL stall_done: seen=%0d cycle %0d want %0d", done_seen, done_cyc, last_hs + 1); end
    step();
  endtask

  task automatic test_nops_edges();
    string exp0 = {"7", term};
    string exp7 = {"9*8+7*6+5", term};
    string got;
    ch_ready = 1'b1;
    load(20'h00007, 4'b0000, 3'd0);
    collect(0, 20, -1);
    got = cap_str();
    n_checks++; if (got != exp0) begin n_fail++; $display("FAIL nops0_seq: got \"%s\" want \"%s\"", got, exp0); end
    n_checks++; if (!done_seen || done_cyc != last_hs + 1) begin n_fail++; $display("FAIL nops0_done: seen=%0d cycle %0d want %0d", done_seen, done_cyc, last_hs + 1); end
    step();
    load(20'h56789, 4'b0101, 3'd7);
    collect(0, 40, -1);
    got = cap_str();
    n_checks++; if (got != exp7) begin n_fail++; $display("FAIL nops_clamp_seq: got \"%s\" (%0d chars) want \"%s\"", got, ncap, exp7); end
    n_checks++; if (!done_seen || err_at_done !== 1'b0) begin n_fail++; $display("FAIL nops_clamp_done: seen=%0d err=%b want 1 0", done_seen, err_at_done); end
    step();
  endtask

  task automatic test_err_busy();
    string exp = {"2+0+3", term};
    string got;
    ch_ready = 1'b1;
    load(20'h003C2, 4'b0000, 3'd2);
    collect(0, 40, 2);
    got = cap_str();
    n_checks++; if (got != exp) begin n_fail++; $display("FAIL err_seq: got \"%s\" want \"%s\"", got, exp); end
    n_checks++; if (!done_seen || err_at_done !== 1'b1) begin n_fail++; $display("FAIL err_with_done: seen=%0d err=%b want 1 1", done_seen, err_at_done); end
    n_checks++; if (err_stray != 0) begin n_fail++; $display("FAIL err_early: got %0d stray pulses want 0", err_stray); end
    step();
    n_checks++; if (err !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL err_pulse: err=%b done=%b want 0 0", err, done); end
    load(20'h00021, 4'b0001, 3'd1);
    collect(0, 20, -1);
    n_checks++; if (err_at_done !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err_at_done); end
    step();
  endtask

  task automatic test_fin_start();
    string exp = {"4", term};
    string got;
    ch_ready = 1'b1;
    load(20'h00510, 4'b0010, 3'd2);
    collect(0, 40, -1);
    digits = 20'h00004; ops = '0; n_ops = '0;
    start  = 1'b1;
    step();
    n_checks++; if (ch_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fin_start_ignored: valid=%b busy=%b want 0 0", ch_valid, busy); end
    step();
    start = 1'b0;
    n_checks++; if (ch_valid !== 1'b1 || ch !== 8'h34) begin n_fail++; $display("FAIL idle_start_accept: valid=%b ch=%h want 1 34", ch_valid, ch); end
    collect(0, 20, -1);
    got = cap_str();
    n_checks++; if (got != exp) begin n_fail++; $display("FAIL fin_restart_seq: got \"%s\" want \"%s\"", got, exp); end
    step();
  endtask

  task automatic test_abort();
    string exp = {"3+4", term};
    string got;
    int dones;
    ch_ready = 1'b1;
    load(20'h00510, 4'b0010, 3'd2);
    step(); step();
    #2 clr_n = 1'b0;
    #1;
    n_checks++; if (ch_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_async: valid=%b busy=%b want 0 0", ch_valid, busy); end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", dones); end
    load(20'h00043, 4'b0000, 3'd1);
    collect(0, 20, -1);
    got = cap_str();
    n_checks++; if (got != exp) begin n_fail++; $display("FAIL abort_restart_seq: got \"%s\" want \"%s\"", got, exp); end
    step();
  endtask

  initial begin
`ifdef EXPR_TERM_EN
    term = "=";
`else
    term = "";
`endif
    test_reset();
    test_basic();
    test_stall();
    test_nops_edges();
    test_err_busy();
    test_fin_start();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_expr_str_tx
`default_nettype wire
